// File: rtl/sfft_frame_reader.sv
// Captures a full SFFT output frame on the valid strobe edge and
// streams its bins out over a valid/ready handshake, bin 0 first.
`ifndef NFFT
`define NFFT 8
`endif
`ifndef nFFT
`define nFFT 3
`endif
`ifndef SFFT_OUTPUT_WIDTH
`define SFFT_OUTPUT_WIDTH 16
`endif

module sfft_frame_reader #(
  parameter int NFFT  = `NFFT,
  parameter int nFFT  = `nFFT,
  parameter int WIDTH = `SFFT_OUTPUT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] SFFT_Out [NFFT],
  input  logic                    OutputValid,
  output logic signed [WIDTH-1:0] bin_data,
  output logic        [nFFT-1:0]  bin_index,
  output logic                    bin_valid,
  output logic                    bin_last,
  input  logic                    bin_ready,
  output logic                    busy,
  output logic        [15:0]      frame_count,
  output logic        [15:0]      drop_count
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t state;

  logic signed [WIDTH-1:0] frameBuf [NFFT];
  logic                    ovPrev;
  logic                    capEvent;
  logic                    accept;
  logic                    lastAcc;
  logic                    load;
  logic        [nFFT-1:0]  nextIdx;

  localparam logic [nFFT-1:0] LastIdx = nFFT'(NFFT - 1);

  assign capEvent = OutputValid & ~ovPrev;
  assign accept   = bin_valid & bin_ready;
  assign lastAcc  = accept & bin_last;
  assign nextIdx  = bin_index + 1'b1;

  // A new frame is only taken when no stream is left unfinished.
  assign load = ~reset & capEvent &
                ((state == IDLE) | lastAcc);

  always_ff @(posedge clk) begin
    if (load) begin
      frameBuf <= SFFT_Out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ovPrev      <= 1'b0;
      bin_data    <= '0;
      bin_index   <= '0;
      bin_valid   <= 1'b0;
      bin_last    <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      ovPrev <= OutputValid;
      unique case (state)
        IDLE: begin
          if (capEvent) begin
            bin_data  <= SFFT_Out[0];
            bin_index <= '0;
            bin_last  <= 1'b0;
            bin_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (lastAcc) begin
            frame_count <= frame_count + 16'd1;
            bin_index   <= '0;
            bin_last    <= 1'b0;
            if (capEvent) begin
              bin_data <= SFFT_Out[0];
            end else begin
              bin_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            if (accept) begin
              bin_index <= nextIdx;
              bin_data  <= frameBuf[nextIdx];
              bin_last  <= (nextIdx == LastIdx);
            end
            if (capEvent && drop_count != 16'hFFFF) begin
              drop_count <= drop_count + 16'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfft_frame_reader.sv
// Directed bench for sfft_frame_reader: stream, stall, drop,
// back-to-back, held strobe, reset and drop saturation.
`timescale 1ns/1ps

module tb_sfft_frame_reader;

  localparam int NFFT  = 8;
  localparam int NB    = 3;
  localparam int WIDTH = 16;

  logic                    clk;
  logic                    reset;
  logic signed [WIDTH-1:0] sfftIn [NFFT];
  logic                    outputValid;
  logic signed [WIDTH-1:0] binData;
  logic        [NB-1:0]    binIndex;
  logic                    binValid;
  logic                    binLast;
  logic                    binReady;
  logic                    busy;
  logic        [15:0]      frameCount;
  logic        [15:0]      dropCount;

  int checks;
  int failures;

  logic [15:0] frameA [NFFT];
  logic [15:0] frameB [NFFT];

  sfft_frame_reader #(
    .NFFT (NFFT),
    .nFFT (NB),
    .WIDTH(WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .SFFT_Out   (sfftIn),
    .OutputValid(outputValid),
    .bin_data   (binData),
    .bin_index  (binIndex),
    .bin_valid  (binValid),
    .bin_last   (binLast),
    .bin_ready  (binReady),
    .busy       (busy),
    .frame_count(frameCount),
    .drop_count (dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    outputValid = 1'b0;
    binReady    = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One-cycle strobe; the input bus is scrambled afterwards.
  task automatic pulse(input logic [15:0] f [NFFT]);
    for (int i = 0; i < NFFT; i++) sfftIn[i] = f[i];
    outputValid = 1'b1;
    step();
    outputValid = 1'b0;
    for (int i = 0; i < NFFT; i++) sfftIn[i] = 16'($urandom);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (binValid !== 1'b0 || busy !== 1'b0 || binLast !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: valid=%b busy=%b last=%b want 0 0 0",
               binValid, busy, binLast);
    end
    checks++;
    if (binIndex !== 3'd0 || binData !== 16'sd0) begin
      failures++;
      $display("FAIL reset_beat: idx=%0d data=%h want 0 0000",
               binIndex, binData);
    end
    checks++;
    if (frameCount !== 16'd0 || dropCount !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts: frame=%0d drop=%0d want 0 0",
               frameCount, dropCount);
    end
  endtask

  task automatic test_basic();
    do_reset();
    binReady = 1'b1;
    pulse(frameA);
    for (int i = 0; i < NFFT; i++) begin
      checks++;
      if (binValid !== 1'b1 || binIndex !== 3'(i) ||
          binData !== frameA[i] || binLast !== (i == NFFT - 1)) begin
        failures++;
        $display("FAIL basic_beat%0d: v=%b idx=%0d data=%h last=%b want 1 %0d %h %b",
                 i, binValid, binIndex, binData, binLast,
                 i, frameA[i], (i == NFFT - 1));
      end
      step();
    end
    checks++;
    if (binValid !== 1'b0 || busy !== 1'b0 || frameCount !== 16'd1) begin
      failures++;
      $display("FAIL basic_end: v=%b busy=%b frame=%0d want 0 0 1",
               binValid, busy, frameCount);
    end
  endtask

  task automatic test_backpressure();
    logic pat [4];
    int   expIdx;
    int   cyc;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    do_reset();
    pulse(frameA);
    expIdx = 0;
    cyc    = 0;
    while (expIdx < NFFT && cyc < 100) begin
      binReady = pat[cyc % 4];
      checks++;
      if (binValid !== 1'b1 || binIndex !== 3'(expIdx) ||
          binData !== frameA[expIdx] ||
          binLast !== (expIdx == NFFT - 1)) begin
        failures++;
        $display("FAIL bp_beat c%0d: v=%b idx=%0d data=%h want 1 %0d %h",
                 cyc, binValid, binIndex, binData,
                 expIdx, frameA[expIdx]);
      end
      if (binReady) expIdx++;
      cyc++;
      step();
    end
    checks++;
    if (expIdx != NFFT) begin
      failures++;
      $display("FAIL bp_timeout: beats=%0d want %0d", expIdx, NFFT);
    end
    binReady = 1'b0;
    checks++;
    if (binValid !== 1'b0 || frameCount !== 16'd1) begin
      failures++;
      $display("FAIL bp_end: v=%b frame=%0d want 0 1",
               binValid, frameCount);
    end
  endtask

  task automatic test_drop();
    do_reset();
    binReady = 1'b1;
    pulse(frameA);
    step();
    step();
    step();
    binReady    = 1'b0;
    outputValid = 1'b1;
    for (int i = 0; i < NFFT; i++) sfftIn[i] = frameB[i];
    step();
    outputValid = 1'b0;
    checks++;
    if (dropCount !== 16'd1 || binIndex !== 3'd3 ||
        binData !== frameA[3]) begin
      failures++;
      $display("FAIL drop_hold: drop=%0d idx=%0d data=%h want 1 3 %h",
               dropCount, binIndex, binData, frameA[3]);
    end
    binReady = 1'b1;
    for (int i = 3; i < NFFT; i++) begin
      checks++;
      if (binValid !== 1'b1 || binIndex !== 3'(i) ||
          binData !== frameA[i]) begin
        failures++;
        $display("FAIL drop_beat%0d: v=%b idx=%0d data=%h want 1 %0d %h",
                 i, binValid, binIndex, binData, i, frameA[i]);
      end
      step();
    end
    checks++;
    if (binValid !== 1'b0 || busy !== 1'b0 ||
        dropCount !== 16'd1 || frameCount !== 16'd1) begin
      failures++;
      $display("FAIL drop_end: v=%b busy=%b drop=%0d frame=%0d want 0 0 1 1",
               binValid, busy, dropCount, frameCount);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    binReady = 1'b1;
    pulse(frameA);
    for (int i = 0; i < NFFT; i++) begin
      checks++;
      if (binValid !== 1'b1 || binIndex !== 3'(i) ||
          binData !== frameA[i]) begin
        failures++;
        $display("FAIL b2b_a%0d: v=%b idx=%0d data=%h want 1 %0d %h",
                 i, binValid, binIndex, binData, i, frameA[i]);
      end
      if (i == NFFT - 1) begin
        outputValid = 1'b1;
        for (int k = 0; k < NFFT; k++) sfftIn[k] = frameB[k];
      end
      step();
    end
    outputValid = 1'b0;
    checks++;
    if (frameCount !== 16'd1 || dropCount !== 16'd0) begin
      failures++;
      $display("FAIL b2b_mid: frame=%0d drop=%0d want 1 0",
               frameCount, dropCount);
    end
    for (int i = 0; i < NFFT; i++) begin
      checks++;
      if (binValid !== 1'b1 || binIndex !== 3'(i) ||
          binData !== frameB[i] || binLast !== (i == NFFT - 1)) begin
        failures++;
        $display("FAIL b2b_b%0d: v=%b idx=%0d data=%h want 1 %0d %h",
                 i, binValid, binIndex, binData, i, frameB[i]);
      end
      step();
    end
    checks++;
    if (binValid !== 1'b0 || frameCount !== 16'd2 ||
        dropCount !== 16'd0) begin
      failures++;
      $display("FAIL b2b_end: v=%b frame=%0d drop=%0d want 0 2 0",
               binValid, frameCount, dropCount);
    end
  endtask

  task automatic test_held_reset();
    do_reset();
    binReady    = 1'b1;
    outputValid = 1'b1;
    for (int i = 0; i < NFFT; i++) sfftIn[i] = frameA[i];
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (binValid !== 1'b1 || binIndex !== 3'(c) ||
          binData !== frameA[c]) begin
        failures++;
        $display("FAIL held_beat%0d: v=%b idx=%0d data=%h want 1 %0d %h",
                 c, binValid, binIndex, binData, c, frameA[c]);
      end
    end
    outputValid = 1'b0;
    step();
    for (int i = 5; i < NFFT; i++) begin
      checks++;
      if (binValid !== 1'b1 || binIndex !== 3'(i) ||
          binData !== frameA[i]) begin
        failures++;
        $display("FAIL held_tail%0d: v=%b idx=%0d data=%h want 1 %0d %h",
                 i, binValid, binIndex, binData, i, frameA[i]);
      end
      step();
    end
    checks++;
    if (binValid !== 1'b0 || frameCount !== 16'd1 ||
        dropCount !== 16'd0) begin
      failures++;
      $display("FAIL held_end: v=%b frame=%0d drop=%0d want 0 1 0",
               binValid, frameCount, dropCount);
    end
    pulse(frameA);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (binIndex !== 3'd4) begin
      failures++;
      $display("FAIL rst_pre: idx=%0d want 4", binIndex);
    end
    reset       = 1'b1;
    outputValid = 1'b1;
    for (int i = 0; i < NFFT; i++) sfftIn[i] = frameB[i];
    step();
    reset       = 1'b0;
    outputValid = 1'b0;
    checks++;
    if (binValid !== 1'b0 || busy !== 1'b0 || binLast !== 1'b0 ||
        binIndex !== 3'd0 || binData !== 16'sd0 ||
        frameCount !== 16'd0 || dropCount !== 16'd0) begin
      failures++;
      $display("FAIL rst_mid: v=%b busy=%b idx=%0d data=%h frame=%0d drop=%0d want 0 0 0 0000 0 0",
               binValid, busy, binIndex, binData, frameCount, dropCount);
    end
    step();
    checks++;
    if (binValid !== 1'b0) begin
      failures++;
      $display("FAIL rst_cap_ignored: v=%b want 0", binValid);
    end
    pulse(frameB);
    for (int i = 0; i < NFFT; i++) begin
      checks++;
      if (binValid !== 1'b1 || binIndex !== 3'(i) ||
          binData !== frameB[i]) begin
        failures++;
        $display("FAIL rst_after%0d: v=%b idx=%0d data=%h want 1 %0d %h",
                 i, binValid, binIndex, binData, i, frameB[i]);
      end
      step();
    end
    checks++;
    if (binValid !== 1'b0 || frameCount !== 16'd1) begin
      failures++;
      $display("FAIL rst_after_end: v=%b frame=%0d want 0 1",
               binValid, frameCount);
    end
  endtask

  task automatic test_drop_saturation();
    do_reset();
    pulse(frameA);
    for (int n = 0; n < 65540; n++) begin
      outputValid = 1'b1;
      sfftIn[0]   = 16'(n);
      step();
      outputValid = 1'b0;
      step();
    end
    checks++;
    if (dropCount !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_drop: drop=%h want ffff", dropCount);
    end
    checks++;
    if (binValid !== 1'b1 || binIndex !== 3'd0 ||
        binData !== frameA[0]) begin
      failures++;
      $display("FAIL sat_hold: v=%b idx=%0d data=%h want 1 0 %h",
               binValid, binIndex, binData, frameA[0]);
    end
    binReady = 1'b1;
    for (int i = 0; i < NFFT; i++) begin
      checks++;
      if (binValid !== 1'b1 || binData !== frameA[i]) begin
        failures++;
        $display("FAIL sat_beat%0d: v=%b data=%h want 1 %h",
                 i, binValid, binData, frameA[i]);
      end
      step();
    end
    checks++;
    if (binValid !== 1'b0 || frameCount !== 16'd1 ||
        dropCount !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_end: v=%b frame=%0d drop=%h want 0 1 ffff",
               binValid, frameCount, dropCount);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    outputValid = 1'b0;
    binReady    = 1'b0;
    for (int i = 0; i < NFFT; i++) sfftIn[i] = '0;
    frameA[0] = 16'h0010; frameA[1] = 16'hFFF0;
    frameA[2] = 16'h0003; frameA[3] = 16'h0004;
    frameA[4] = 16'h0005; frameA[5] = 16'h0006;
    frameA[6] = 16'h0007; frameA[7] = 16'h7FFF;
    frameB[0] = 16'h8000; frameB[1] = 16'h1234;
    frameB[2] = 16'hABCD; frameB[3] = 16'h0F0F;
    frameB[4] = 16'hFFFF; frameB[5] = 16'h0001;
    frameB[6] = 16'h5555; frameB[7] = 16'hAAAA;
    test_reset();
    test_basic();
    test_backpressure();
    test_drop();
    test_back_to_back();
    test_held_reset();
    test_drop_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
